// File: rtl/alu_seq.sv
// alu_seq: multi-word sequencer around the single-cycle ALU.
//
// A wide operation (WORDS words of WIDTH bits) is accepted through the
// start/busy/done handshake and issued to the external ALU one word per
// clock. Carry, borrow and shift bits are chained between words in cb.
// Optional feature macro: ALU_SEQ_ZFLAG_EN builds the zero-result flag
// register. Without it, zero is tied low.
//
// The opcode localparams mirror the instr_set.v encoding used by the ALU.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 4,
  parameter int WORDS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IWIDTH-1:0]        op,
  input  logic [WIDTH*WORDS-1:0]   opa,
  input  logic [WIDTH*WORDS-1:0]   opb,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH*WORDS-1:0]   result,
  output logic                     cy,
  output logic                     zero,
  output logic [IWIDTH-1:0]        alu_instr,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_c_in,
  output logic                     alu_b_in,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_c_out,
  input  logic                     alu_b_out,
  input  logic                     alu_flag_valid
);

  localparam int W  = WIDTH * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  localparam logic [IWIDTH-1:0] OP_NOP = IWIDTH'(0);
  localparam logic [IWIDTH-1:0] OP_ADD = IWIDTH'(1);
  localparam logic [IWIDTH-1:0] OP_SUB = IWIDTH'(2);
  localparam logic [IWIDTH-1:0] OP_INC = IWIDTH'(3);
  localparam logic [IWIDTH-1:0] OP_DEC = IWIDTH'(4);
  localparam logic [IWIDTH-1:0] OP_NOT = IWIDTH'(5);
  localparam logic [IWIDTH-1:0] OP_XOR = IWIDTH'(6);
  localparam logic [IWIDTH-1:0] OP_OR  = IWIDTH'(7);
  localparam logic [IWIDTH-1:0] OP_AND = IWIDTH'(8);
  localparam logic [IWIDTH-1:0] OP_RL  = IWIDTH'(9);
  localparam logic [IWIDTH-1:0] OP_RR  = IWIDTH'(10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx;
  logic              cb, cb_nxt;
  logic [IWIDTH-1:0] op_q;
  logic [W-1:0]      opa_q, opb_q;
  logic [W-1:0]      acc, acc_nxt;
  logic [IW-1:0]     word_sel;
  logic [WIDTH-1:0]  a_word, b_word, res_word;
  logic              accept, last, finish;

  // The ALU only knows ADD/SUB; INC/DEC ride on them with a zero operand
  // and the chain bit preloaded to 1.
  function automatic logic [IWIDTH-1:0] xlate_op(input logic [IWIDTH-1:0] o);
    if (o == OP_INC)      return OP_ADD;
    else if (o == OP_DEC) return OP_SUB;
    else                  return o;
  endfunction

  // The flag-valid strobe carries no information for a fixed one-cycle ALU.
  logic unused_ok;
  assign unused_ok = &{1'b0, alu_flag_valid};

  assign accept = start && (state != S_RUN);
  assign last   = (idx == LAST_IDX);
  assign finish = (state == S_RUN) && last;
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  // Next-state logic; DONE lasts one cycle unless a new start chains on.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Word issue to the ALU and chain-bit / result-word computation.
  always_comb begin
    alu_instr = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_c_in  = 1'b0;
    alu_b_in  = 1'b0;
    word_sel  = (op_q == OP_RR) ? (LAST_IDX - idx) : idx;
    a_word    = opa_q[word_sel*WIDTH +: WIDTH];
    b_word    = opb_q[word_sel*WIDTH +: WIDTH];
    res_word  = alu_out;
    cb_nxt    = 1'b0;
    acc_nxt   = acc;
    if (state == S_RUN) begin
      alu_instr = xlate_op(op_q);
      alu_a     = a_word;
      alu_b     = ((op_q == OP_INC) || (op_q == OP_DEC)) ? '0 : b_word;
      case (op_q)
        OP_ADD, OP_INC: begin
          alu_c_in = cb;
          cb_nxt   = alu_c_out;
        end
        OP_SUB, OP_DEC: begin
          alu_b_in = cb;
          cb_nxt   = alu_b_out;
        end
        OP_RL: begin
          res_word = alu_out | {{(WIDTH-1){1'b0}}, cb};
          cb_nxt   = a_word[WIDTH-1];
        end
        OP_RR: begin
          res_word = alu_out | {cb, {(WIDTH-1){1'b0}}};
          cb_nxt   = a_word[0];
        end
        default: cb_nxt = 1'b0;
      endcase
      acc_nxt[word_sel*WIDTH +: WIDTH] = res_word;
    end
  end

  // Word index and chain bit; INC/DEC start with an injected carry/borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cb  <= 1'b0;
    end else if (accept) begin
      idx <= '0;
      cb  <= (op == OP_INC) || (op == OP_DEC);
    end else if (state == S_RUN) begin
      idx <= idx + 1'b1;
      cb  <= cb_nxt;
    end
  end

  // Operand latch and working accumulator; no reset needed on pure data.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= op;
      opa_q <= opa;
      opb_q <= opb;
    end
    if (state == S_RUN) acc <= acc_nxt;
  end

  // Visible result and carry only move at the final capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cy     <= 1'b0;
    end else if (finish) begin
      result <= acc_nxt;
      cy     <= cb_nxt;
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  logic zero_q;

  // Zero flag tracks the completed result.
  always_ff @(posedge clk) begin
    if (rst)         zero_q <= 1'b0;
    else if (finish) zero_q <= (acc_nxt == '0);
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8, WORDS=4).
// A behavioural single-cycle ALU answers the alu_* ports; expected wide
// results come from plain 32-bit arithmetic on whole operands.
module tb_alu_seq;

  localparam int WIDTH  = 8;
  localparam int IWIDTH = 4;
  localparam int WORDS  = 4;
  localparam int W      = WIDTH * WORDS;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_INC = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_RL  = 4'd9;
  localparam logic [3:0] OP_RR  = 4'd10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       op;
  logic [W-1:0]     opa, opb;
  logic             busy, done, cy, zero;
  logic [W-1:0]     result;
  logic [3:0]       alu_instr;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             alu_c_in, alu_b_in, alu_c_out, alu_b_out, alu_flag_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .cy(cy), .zero(zero),
    .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c_in(alu_c_in), .alu_b_in(alu_b_in), .alu_out(alu_out),
    .alu_c_out(alu_c_out), .alu_b_out(alu_b_out),
    .alu_flag_valid(alu_flag_valid)
  );

  // Behavioural single-cycle ALU.
  assign alu_flag_valid = 1'b1;
  always_comb begin
    alu_out   = alu_b;
    alu_c_out = 1'b0;
    alu_b_out = 1'b0;
    case (alu_instr)
      OP_ADD: {alu_c_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
      OP_SUB: {alu_b_out, alu_out} = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_b_in};
      OP_NOT: alu_out = ~alu_a;
      OP_XOR: alu_out = alu_a ^ alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_AND: alu_out = alu_a & alu_b;
      OP_RL:  alu_out = {alu_a[WIDTH-2:0], 1'b0};
      OP_RR:  alu_out = {1'b0, alu_a[WIDTH-1:1]};
      default: alu_out = alu_b;
    endcase
  end

  // Whole-operand reference: the wide operation as ordinary 32-bit math.
  function automatic void ref_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c);
    logic [W:0] t;
    t = '0;
    r = b;
    c = 1'b0;
    case (o)
      OP_ADD: begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W]; end
      OP_SUB: begin r = a - b; c = (a < b); end
      OP_INC: begin r = a + 32'd1; c = (a == 32'hFFFF_FFFF); end
      OP_DEC: begin r = a - 32'd1; c = (a == 32'd0); end
      OP_NOT: r = ~a;
      OP_XOR: r = a ^ b;
      OP_OR:  r = a | b;
      OP_AND: r = a & b;
      OP_RL:  begin r = {a[W-2:0], 1'b0}; c = a[W-1]; end
      OP_RR:  begin r = {1'b0, a[W-1:1]}; c = a[0]; end
      default: begin r = b; c = 1'b0; end
    endcase
  endfunction

  function automatic logic exp_zero(input logic [W-1:0] r);
`ifdef ALU_SEQ_ZFLAG_EN
    return (r == '0);
`else
    return 1'b0 & (r == '0);
`endif
  endfunction

  // Present one start pulse; returns one cycle after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    opa   = a;
    opb   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance until done is seen (bounded), counting busy cycles on the way.
  task automatic wait_done(output int busy_cyc, output bit ok);
    busy_cyc = 0;
    ok       = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (done) ok = 1'b1;
      else begin
        if (busy) busy_cyc++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, cy, zero} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, cy, zero});
    end
    n_checks++;
    if (result !== '0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    n_checks++;
    if ({alu_instr, alu_a, alu_b, alu_c_in, alu_b_in} !== '0) begin
      n_fail++; $display("FAIL reset_alu: got instr %h a %h b %h ci %b bi %b expected all 0",
                         alu_instr, alu_a, alu_b, alu_c_in, alu_b_in);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [3:0]   d_op [8] = '{OP_ADD, OP_SUB, OP_INC, OP_RL, OP_RR, OP_XOR, OP_NOP, OP_DEC};
    logic [W-1:0] d_a  [8] = '{32'h00FF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8080_8080,
                               32'h0101_0101, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000};
    logic [W-1:0] d_b  [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000,
                               32'h0000_0000, 32'hFFFF_0000, 32'h1234_5678, 32'h0000_0000};
    logic [W-1:0] d_r  [8] = '{32'h0100_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0101_0100,
                               32'h0080_8080, 32'h5A5A_A5A5, 32'h1234_5678, 32'hFFFF_FFFF};
    logic         d_c  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int bc;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
      wait_done(bc, ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL dir%0d_timeout: got no done expected done", i);
      end
      n_checks++;
      if (bc != WORDS) begin
        n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, WORDS);
      end
      n_checks++;
      if (result !== d_r[i]) begin
        n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, result, d_r[i]);
      end
      n_checks++;
      if (cy !== d_c[i]) begin
        n_fail++; $display("FAIL dir%0d_cy: got %b expected %b", i, cy, d_c[i]);
      end
      n_checks++;
      if (zero !== exp_zero(d_r[i])) begin
        n_fail++; $display("FAIL dir%0d_zero: got %b expected %b", i, zero, exp_zero(d_r[i]));
      end
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done} !== 2'b00 || result !== d_r[i]) begin
        n_fail++; $display("FAIL dir%0d_after_done: got busy %b done %b result %h expected 0 0 %h",
                           i, busy, done, result, d_r[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0]   o;
    logic [W-1:0] a, b, er;
    logic         ec;
    int bc;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) a = 32'hFFFF_FFFF;
      if (i % 5 == 2) a = 32'h0000_0000;
      if (i % 7 == 3) b = ~a;
      ref_op(o, a, b, er, ec);
      issue(o, a, b);
      wait_done(bc, ok);
      n_checks++;
      if (!ok || bc != WORDS || result !== er || cy !== ec || zero !== exp_zero(er)) begin
        n_fail++;
        $display("FAIL rand%0d op %0d a %h b %h: got ok %b busy %0d res %h cy %b z %b expected 1 %0d %h %b %b",
                 i, o, a, b, ok, bc, result, cy, zero, WORDS, er, ec, exp_zero(er));
      end
    end
  endtask

  task automatic test_ignore_start;
    int bc;
    bit ok;
    issue(OP_ADD, 32'h1111_1111, 32'h2222_2222);
    @(posedge clk); #1;
    op = OP_SUB; opa = 32'hDEAD_BEEF; opb = 32'h0BAD_F00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(bc, ok);
    bc = bc + 2;
    n_checks++;
    if (!ok || bc != WORDS) begin
      n_fail++; $display("FAIL ignore_busy_cycles: got ok %b cycles %0d expected 1 %0d", ok, bc, WORDS);
    end
    n_checks++;
    if (result !== 32'h3333_3333) begin
      n_fail++; $display("FAIL ignore_result: got %h expected 33333333", result);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL ignore_not_queued: got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int bc, gap;
    bit ok;
    issue(OP_OR, 32'h0F0F_0000, 32'h0000_F0F0);
    wait_done(bc, ok);
    n_checks++;
    if (!ok || result !== 32'h0F0F_F0F0) begin
      n_fail++; $display("FAIL b2b_first: got ok %b result %h expected 1 0f0ff0f0", ok, result);
    end
    issue(OP_AND, 32'hFF00_FF00, 32'h1234_5678);
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_no_gap: got busy %b done %b expected 1 0", busy, done);
    end
    n_checks++;
    if (result !== 32'h0F0F_F0F0) begin
      n_fail++; $display("FAIL b2b_result_held: got %h expected 0f0ff0f0", result);
    end
    wait_done(bc, ok);
    gap = bc + 1;
    n_checks++;
    if (!ok || gap != 5) begin
      n_fail++; $display("FAIL b2b_done_spacing: got ok %b spacing %0d expected 1 5", ok, gap);
    end
    n_checks++;
    if (result !== 32'h1200_5600) begin
      n_fail++; $display("FAIL b2b_second: got %h expected 12005600", result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int bc, seen;
    bit ok;
    issue(OP_ADD, 32'h0102_0304, 32'h1010_1010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00 || result !== '0 || cy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_run: got busy %b done %b result %h cy %b expected 0 0 0 0",
                         busy, done, result, cy);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_no_done: got %0d active cycles expected 0", seen);
    end
    issue(OP_SUB, 32'h1000_0000, 32'h0000_0001);
    wait_done(bc, ok);
    n_checks++;
    if (!ok || bc != WORDS || result !== 32'h0FFF_FFFF || cy !== 1'b0) begin
      n_fail++; $display("FAIL rst_then_run: got ok %b busy %0d result %h cy %b expected 1 %0d 0fffffff 0",
                         ok, bc, result, cy, WORDS);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-word sequencer that wraps the single-cycle ALU to execute arithmetic, logic and shift operations on operands WORDS times wider than the ALU datapath. It accepts one wide operation through a start/busy/done handshake and issues it to the ALU one word per clock, chaining carry, borrow and shift bits between words. It sits beside the ALU, which stays a separate instance wired to the alu_* ports. It is used for wide accumulator arithmetic that the one-cycle core cannot perform directly.

## Interface
- WIDTH, 8, ALU word width in bits
- IWIDTH, 4, opcode width; opcodes are the instr_set.v macros
- WORDS, 4, words per wide operand (≥2); wide width W = WIDTH*WORDS
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- op  in  IWIDTH  operation, latched on accepted start
- opa, opb  in  W  wide operands, latched on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when result and flags are valid
- result  out  W  wide result, held until the next accepted start
- cy  out  1  final carry (ADD/INC), borrow (SUB/DEC) or shifted-out bit (RL/RR); 0 for other ops
- zero  out  1  result == 0 (see Configuration)
- alu_instr  out  IWIDTH  opcode driven to the ALU
- alu_a, alu_b  out  WIDTH  current word operands
- alu_c_in, alu_b_in  out  1  chained carry / borrow into the ALU
- alu_out  in  WIDTH  ALU result word
- alu_c_out, alu_b_out, alu_flag_valid  in  1  ALU flags

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE after the last word.
  - DONE→RUN on start, else DONE→IDLE.
- Accepted start latches op, opa and opb, clears the word index, and loads the chain bit cb:
  - cb=1 for INC/DEC.
  - cb=0 for all other ops.
- Op translation:
  - INC is issued as ADD with alu_b=0.
  - DEC is issued as SUB with alu_b=0.
  - All other ops pass through unchanged.
- Word order:
  - Word 0 (LSB) upward for ADD, SUB, INC, DEC, RL and the logic ops.
  - Word WORDS-1 downward for RR.
- Each RUN cycle drives word i of each operand. The ALU's response is captured into result word i, and cb is updated:
  - ADD/INC: cb←alu_c_out; alu_c_in=cb.
  - SUB/DEC: cb←alu_b_out; alu_b_in=cb.
  - RL: result word = alu_out | cb; cb←opa word[WIDTH-1].
  - RR: result word = alu_out | (cb<<WIDTH-1); cb←opa word[0].
  - NOT, XOR, OR, AND, and any other op (ALU pass-through of alu_b): cb held 0.
- When not used for chaining, alu_c_in and alu_b_in are 0. In IDLE, alu_instr, alu_a and alu_b are 0.
- cy = cb after the last word. zero is computed from the final result.
- start while busy is ignored. No queueing.

## Timing
- Reset values: state IDLE; busy=0, done=0, result=0, cy=0, zero=0; alu_* outputs 0.
- Reset asserted in any state, including mid-RUN:
  - Aborts at the next edge; partial result is discarded and result clears to 0.
  - No done pulse is produced.
- Latency, with start sampled at edge E0:
  - busy rises after E0.
  - Word i is captured at E(i+1).
  - After E(WORDS): busy=0 and done=1 for exactly one cycle.
- Back-to-back: start in the DONE cycle is accepted. busy rises in the next cycle with no IDLE gap, and done falls.
- result, cy and zero change only at the final capture edge or reset. They are stable from done until the next completion.
- The ALU path is combinational within one cycle; there is no wait state.

## Configuration
- ALU_SEQ_ZFLAG_EN defined: zero is a register, updated at the final capture edge with (final result == 0), and held until the next completion.
- Not defined: zero is tied to 0 and the zero register and comparator are not built.

## Test plan
All scenarios use WIDTH=8, WORDS=4.
- ADD 0x00FFFFFF + 0x00000001:
  - Exactly 4 busy cycles, then done.
  - result=0x01000000, cy=0, zero=0.
- SUB 0x00000000 − 0x00000001 → result=0xFFFFFFFF, cy=1. INC 0xFFFFFFFF → result=0x00000000, cy=1, zero=1 (with ALU_SEQ_ZFLAG_EN).
- RL 0x80808080 → result=0x01010100, cy=1. RR 0x01010101 → result=0x00808080, cy=1.
- XOR 0xA5A5A5A5 ^ 0xFFFF0000 → result=0x5A5AA5A5, cy=0. NOP with opb=0x12345678 → result=0x12345678.
- start pulsed mid-RUN is ignored. start in the DONE cycle gives a second done exactly 5 cycles after the first.
- rst asserted in RUN at word 2:
  - Next cycle: busy=0, result=0, state IDLE.
  - No done pulse.
  - A following start completes normally.
